// File: rtl/ram2e_cmd_seq.sv
// Command-sequence recognizer for RAM2E: tracks the six-byte unlock prefix written
// to the RAMWorks bank register, arms one-shot command triggers, and holds the bank byte.
module ram2e_cmd_seq #(
  parameter logic [7:0] TIMEOUT  = 8'd255,
  parameter logic [7:0] CMD_MASK = 8'hE0,
  parameter logic [7:0] CMD_LED  = 8'hE2
) (
  input  logic       C14M,
  input  logic       nRST,
  input  logic [3:0] S,
  input  logic       RWSel,
  input  logic [7:0] D,
  output logic [2:0] CS,
  output logic       CmdRWMaskSet,
  output logic       CmdLEDSet,
  output logic [7:0] RWBank
);

  typedef enum logic [2:0] {
    CS_IDLE = 3'd0,
    CS_P1   = 3'd1,
    CS_P2   = 3'd2,
    CS_P3   = 3'd3,
    CS_P4   = 3'd4,
    CS_P5   = 3'd5,
    CS_CMD  = 3'd6,
    CS_DATA = 3'd7
  } cs_e;

  cs_e        cs_q, cs_d;
  logic       mask_q, mask_d;
  logic       led_q, led_d;
  logic [7:0] bank_q, bank_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr;
  logic       cyc_start;

  // Byte expected while the sequence sits in prefix state k.
  function automatic logic [7:0] prefix_byte(input logic [2:0] k);
    logic [7:0] b;
    case (k)
      3'd0:    b = 8'hFF;
      3'd1:    b = 8'h00;
      3'd2:    b = 8'h55;
      3'd3:    b = 8'hAA;
      3'd4:    b = 8'hC1;
      3'd5:    b = 8'hAD;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign wr        = (S == 4'hC) && RWSel;
  assign cyc_start = (S == 4'h0);

  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      cs_q   <= CS_IDLE;
      mask_q <= 1'b0;
      led_q  <= 1'b0;
      bank_q <= 8'h00;
      cnt_q  <= 8'h00;
    end else begin
      cs_q   <= cs_d;
      mask_q <= mask_d;
      led_q  <= led_d;
      bank_q <= bank_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    cs_d   = cs_q;
    mask_d = mask_q;
    led_d  = led_q;
    bank_d = bank_q;
    cnt_d  = cnt_q;
    if (wr) begin
      bank_d = D;
      cnt_d  = 8'h00;
      case (cs_q)
        CS_CMD: begin
          cs_d   = CS_DATA;
          mask_d = (D == CMD_MASK);
          led_d  = (D == CMD_LED);
        end
        CS_DATA: begin
          cs_d   = (D == 8'hFF) ? CS_P1 : CS_IDLE;
          mask_d = 1'b0;
          led_d  = 1'b0;
        end
        default: begin
          if (D == prefix_byte(cs_q))
            cs_d = cs_e'(cs_q + 3'd1);
          else if (D == 8'hFF)
            cs_d = CS_P1;
          else
            cs_d = CS_IDLE;
        end
      endcase
    end else if (cs_q == CS_IDLE) begin
      cnt_d = 8'h00;
    end else if (cyc_start) begin
      // The edge that would bring the count to TIMEOUT abandons the sequence instead.
      if (cnt_q >= TIMEOUT - 8'd1) begin
        cs_d   = CS_IDLE;
        mask_d = 1'b0;
        led_d  = 1'b0;
        cnt_d  = 8'h00;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign CS           = cs_q;
  assign CmdRWMaskSet = mask_q;
  assign CmdLEDSet    = led_q;
  assign RWBank       = bank_q;

endmodule

// File: tb/tb_ram2e_cmd_seq.sv
// Self-checking bench for ram2e_cmd_seq: vector table of bank writes with a scoreboard,
// plus hand-written timeout and asynchronous-reset sequences.
module tb_ram2e_cmd_seq;

  logic       C14M;
  logic       nRST;
  logic [3:0] S;
  logic       RWSel;
  logic [7:0] D;
  logic [2:0] CS;
  logic       CmdRWMaskSet;
  logic       CmdLEDSet;
  logic [7:0] RWBank;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] d;
    logic [2:0] cs;
    logic       mask;
    logic       led;
  } vec_t;

  typedef struct {
    logic [2:0] cs;
    logic       mask;
    logic       led;
    logic [7:0] bank;
  } exp_t;

  vec_t tbl[30];
  exp_t sb[$];

  ram2e_cmd_seq #(
    .TIMEOUT (8'd255),
    .CMD_MASK(8'hE0),
    .CMD_LED (8'hE2)
  ) dut (
    .C14M        (C14M),
    .nRST        (nRST),
    .S           (S),
    .RWSel       (RWSel),
    .D           (D),
    .CS          (CS),
    .CmdRWMaskSet(CmdRWMaskSet),
    .CmdLEDSet   (CmdLEDSet),
    .RWBank      (RWBank)
  );

  initial C14M = 1'b0;
  always #5 C14M = ~C14M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] ecs, input logic emask,
                             input logic eled, input logic [7:0] ebank);
    check({name, ".CS"}, 32'(CS), 32'(ecs));
    check({name, ".mask"}, 32'(CmdRWMaskSet), 32'(emask));
    check({name, ".led"}, 32'(CmdLEDSet), 32'(eled));
    check({name, ".bank"}, 32'(RWBank), 32'(ebank));
  endtask

  // One full bus cycle (S = 0..F); a write pops and compares the scoreboard after its edge.
  task automatic bus_cycle(input logic rw, input logic [7:0] data);
    exp_t e;
    for (int s = 0; s < 16; s++) begin
      S     = 4'(s);
      RWSel = rw;
      D     = data;
      @(posedge C14M);
      #1;
      if (rw && s == 12) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: write with no expectation queued, D=%0h", data);
        end else begin
          e = sb.pop_front();
          check_state("write", e.cs, e.mask, e.led, e.bank);
        end
      end
    end
    RWSel = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] ecs, input logic emask,
                      input logic eled);
    exp_t e;
    e.cs   = ecs;
    e.mask = emask;
    e.led  = eled;
    e.bank = d;
    sb.push_back(e);
    bus_cycle(1'b1, d);
  endtask

  task automatic send_prefix();
    logic [7:0] pfx[6];
    pfx = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD};
    for (int i = 0; i < 6; i++) send(pfx[i], 3'(i + 1), 1'b0, 1'b0);
  endtask

  initial begin
    // Test 1: LED command
    tbl[0]  = '{8'hFF, 3'd1, 1'b0, 1'b0};
    tbl[1]  = '{8'h00, 3'd2, 1'b0, 1'b0};
    tbl[2]  = '{8'h55, 3'd3, 1'b0, 1'b0};
    tbl[3]  = '{8'hAA, 3'd4, 1'b0, 1'b0};
    tbl[4]  = '{8'hC1, 3'd5, 1'b0, 1'b0};
    tbl[5]  = '{8'hAD, 3'd6, 1'b0, 1'b0};
    tbl[6]  = '{8'hE2, 3'd7, 1'b0, 1'b1};
    tbl[7]  = '{8'h01, 3'd0, 1'b0, 1'b0};
    // Test 2: capacity mask command
    tbl[8]  = '{8'hFF, 3'd1, 1'b0, 1'b0};
    tbl[9]  = '{8'h00, 3'd2, 1'b0, 1'b0};
    tbl[10] = '{8'h55, 3'd3, 1'b0, 1'b0};
    tbl[11] = '{8'hAA, 3'd4, 1'b0, 1'b0};
    tbl[12] = '{8'hC1, 3'd5, 1'b0, 1'b0};
    tbl[13] = '{8'hAD, 3'd6, 1'b0, 1'b0};
    tbl[14] = '{8'hE0, 3'd7, 1'b1, 1'b0};
    tbl[15] = '{8'h3C, 3'd0, 1'b0, 1'b0};
    // Test 3: broken prefix, then restart path
    tbl[16] = '{8'hFF, 3'd1, 1'b0, 1'b0};
    tbl[17] = '{8'h00, 3'd2, 1'b0, 1'b0};
    tbl[18] = '{8'h55, 3'd3, 1'b0, 1'b0};
    tbl[19] = '{8'h12, 3'd0, 1'b0, 1'b0};
    tbl[20] = '{8'hFF, 3'd1, 1'b0, 1'b0};
    tbl[21] = '{8'hFF, 3'd1, 1'b0, 1'b0};
    // Test 6: unknown command byte (starts from CS=1; FF restarts to 1)
    tbl[22] = '{8'hFF, 3'd1, 1'b0, 1'b0};
    tbl[23] = '{8'h00, 3'd2, 1'b0, 1'b0};
    tbl[24] = '{8'h55, 3'd3, 1'b0, 1'b0};
    tbl[25] = '{8'hAA, 3'd4, 1'b0, 1'b0};
    tbl[26] = '{8'hC1, 3'd5, 1'b0, 1'b0};
    tbl[27] = '{8'hAD, 3'd6, 1'b0, 1'b0};
    tbl[28] = '{8'h77, 3'd7, 1'b0, 1'b0};
    tbl[29] = '{8'h5A, 3'd0, 1'b0, 1'b0};

    nRST  = 1'b0;
    S     = 4'h1;
    RWSel = 1'b0;
    D     = 8'h00;
    repeat (3) @(posedge C14M);
    #1;
    check_state("reset", 3'd0, 1'b0, 1'b0, 8'h00);
    #2 nRST = 1'b1;
    @(posedge C14M);
    #1;

    for (int i = 0; i < 30; i++) send(tbl[i].d, tbl[i].cs, tbl[i].mask, tbl[i].led);

    // Trigger must still be high mid-way through the following idle bus cycle.
    send_prefix();
    send(8'hE2, 3'd7, 1'b0, 1'b1);
    bus_cycle(1'b0, 8'h00);
    check_state("led_held", 3'd7, 1'b0, 1'b1, 8'hE2);
    send(8'h01, 3'd0, 1'b0, 1'b0);

    // Test 4: timeout from CS=6 after 255 idle bus cycles
    send_prefix();
    for (int k = 1; k <= 256; k++) begin
      bus_cycle(1'b0, 8'(k));
      if (k == 1 || k == 254) check_state("tmo6_wait", 3'd6, 1'b0, 1'b0, 8'hAD);
      if (k == 255 || k == 256) check_state("tmo6_fire", 3'd0, 1'b0, 1'b0, 8'hAD);
    end

    // Timeout while a trigger is armed clears it
    send_prefix();
    send(8'hE0, 3'd7, 1'b1, 1'b0);
    for (int k = 1; k <= 255; k++) begin
      bus_cycle(1'b0, 8'h00);
      if (k == 254) check_state("tmo7_wait", 3'd7, 1'b1, 1'b0, 8'hE0);
      if (k == 255) check_state("tmo7_fire", 3'd0, 1'b0, 1'b0, 8'hE0);
    end

    // Test 5: asynchronous reset with CS=7 and LED trigger armed
    send_prefix();
    send(8'hE2, 3'd7, 1'b0, 1'b1);
    for (int s = 0; s < 5; s++) begin
      S = 4'(s);
      @(posedge C14M);
      #1;
    end
    #2 nRST = 1'b0;
    #1;
    check_state("async_rst", 3'd0, 1'b0, 1'b0, 8'h00);
    @(posedge C14M);
    #3 nRST = 1'b1;
    @(posedge C14M);
    #1;
    check_state("after_rst", 3'd0, 1'b0, 1'b0, 8'h00);
    send(8'hFF, 3'd1, 1'b0, 1'b0);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
